vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter SYNC_DLY, default 1, legal 1..4: pipeline stages applied to vga_hs/vga_vs/vga_de.
REQ-003 Parameter H_TOTAL, default 800: line length in clocks; V_TOTAL, default 525: frame length in lines.
REQ-004 Port clk  in  1  pixel clock (25 MHz for 640x480@60).
REQ-005 Port rst  in  1  asynchronous active-high reset.
REQ-006 Port en  in  1  run request (e.g. SDRAM init done); level-sensitive.
REQ-007 Port value_x  out  11  horizontal count, 1..H_TOTAL while running, 0 when idle.
REQ-008 Port value_y  out  11  vertical count, 1..V_TOTAL while running, 0 when idle.
REQ-009 Port vga_hs  out  1  horizontal sync, active low.
REQ-010 Port vga_vs  out  1  vertical sync, active low.
REQ-011 Port vga_de  out  1  display enable, high for the 640x480 active window.
REQ-012 Port frame_start  out  1  one-clock pulse at the first clock of each frame.
REQ-013 Port running  out  1  high while the FSM is in RUN or STOPPING.

Function
REQ-014 FSM SHALL have states IDLE, RUN, STOPPING; IDLE->RUN when en=1; RUN->STOPPING when en=0; STOPPING->RUN when en=1; STOPPING->IDLE on the clock the frame ends (value_x=H_TOTAL, value_y=V_TOTAL).
REQ-015 On IDLE->RUN, the next clock SHALL show value_x=1, value_y=1, frame_start=1.
REQ-016 In RUN/STOPPING, value_x SHALL increment each clock and wrap H_TOTAL->1; value_y SHALL increment on that wrap and wrap V_TOTAL->1.
REQ-017 frame_start SHALL be 1 exactly when value_x=1 and value_y=1 (undelayed), else 0.
REQ-018 Horizontal layout: active 51..690, front porch 691..706, sync 707..800 and 1..2 (96 clocks), back porch 3..50.
REQ-019 Vertical layout: active 1..480, front porch 481..490, sync 491..492, back porch 493..525.
REQ-020 Undelayed hs/vs/de SHALL be decoded from value_x/value_y and passed through SYNC_DLY register stages, so the default aligns with one-cycle-registered downstream rgb.
REQ-021 In IDLE, value_x/value_y SHALL be 0, delayed pipeline input SHALL be hs=1, vs=1, de=0; pipeline drains normally.
REQ-022 en toggling mid-frame SHALL never truncate a frame; only whole frames are emitted.
REQ-023 Counter compares SHALL be on full 11-bit unsigned values; no intermediate wider arithmetic.

Reset
REQ-024 On rst: FSM=IDLE, value_x=0, value_y=0, vga_hs=1, vga_vs=1, vga_de=0, frame_start=0, running=0, all delay stages filled with idle values.
REQ-025 rst asserted mid-frame SHALL abort immediately; after release with en=1 the next frame starts from (1,1).

Configuration
REQ-026 Macro VGA_TIMING_FRAME_CNT_EN defined: add output frame_cnt (16 bits, reset 0), incremented on each frame_start, wrapping 65535->0.
REQ-027 Macro undefined: no frame_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-028 Shared package vga_pkg SHALL hold H/V active, porch and sync constants and the FSM state typedef.
REQ-029 Sub-module vga_sync_dly SHALL implement the SYNC_DLY-deep shift register for {hs, vs, de} with reset value {1,1,0}.

Verification
REQ-030 rst then en=1 at cycle 0 -> cycle 1 value_x=1, value_y=1, frame_start=1; running=1.
REQ-031 Run one line, SYNC_DLY=1 -> vga_de high for 640 clocks starting one clock after value_x=51; vga_hs low for 96 clocks starting one clock after value_x=707.
REQ-032 Run one full frame -> exactly 420000 clocks between frame_start pulses; vga_vs low for 1600 clocks; 307200 vga_de-high clocks.
REQ-033 Drop en at value_y=100 -> frame completes to (800,525), then value_x=value_y=0, running=0, no further frame_start.
REQ-034 Drop en then re-raise before frame end -> no gap; next frame_start follows immediately after (800,525).
REQ-035 Assert rst at value_y=200 with VGA_TIMING_FRAME_CNT_EN defined after 3 frames -> all outputs at reset values, frame_cnt=0 within the same clock.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants, FSM state type and sync decode for the VGA timing generator.
// Counters run 1..TOTAL; each region is described by the last count it occupies.
package vga_pkg;

  localparam int CNT_W = 11;

  // Horizontal regions in line order: sync tail, back porch, active, front porch, sync head
  localparam logic [CNT_W-1:0] H_SYNC_END = 11'd2;
  localparam logic [CNT_W-1:0] H_BP_END   = 11'd50;
  localparam logic [CNT_W-1:0] H_ACT_END  = 11'd690;
  localparam logic [CNT_W-1:0] H_FP_END   = 11'd706;

  // Vertical regions in frame order: active, front porch, sync, back porch
  localparam logic [CNT_W-1:0] V_ACT_END  = 11'd480;
  localparam logic [CNT_W-1:0] V_FP_END   = 11'd490;
  localparam logic [CNT_W-1:0] V_SYNC_END = 11'd492;

  // {hs, vs, de} while idle or in reset
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  // Horizontal sync straddles the line wrap, so it is low at both ends of the count range.
  function automatic logic [2:0] decode_sync(input logic [CNT_W-1:0] x, input logic [CNT_W-1:0] y);
    logic hs;
    logic vs;
    logic de;
    hs = !((x > H_FP_END) || ((x != '0) && (x <= H_SYNC_END)));
    vs = !((y > V_FP_END) && (y <= V_SYNC_END));
    de = (x > H_BP_END) && (x <= H_ACT_END) && (y != '0) && (y <= V_ACT_END);
    return {hs, vs, de};
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Port bundle of the VGA timing generator: run request in, counters and syncs out.
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic             en;
  logic [CNT_W-1:0] value_x;
  logic [CNT_W-1:0] value_y;
  logic             vga_hs;
  logic             vga_vs;
  logic             vga_de;
  logic             frame_start;
  logic             running;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]      frame_cnt;
`endif

  modport master (
    input  en,
    output value_x, value_y, vga_hs, vga_vs, vga_de, frame_start, running
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output en,
    input  value_x, value_y, vga_hs, vga_vs, vga_de, frame_start, running
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/vga_sync_dly.sv
// DEPTH-stage shift register for {hs, vs, de}; every stage resets to the idle pattern.
module vga_sync_dly
  import vga_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] din,
  output logic [2:0] dout
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [2:0] q_reg;
    if (gi == 0) begin : g_first
      always_ff @(posedge clk or posedge rst) begin
        if (rst) q_reg <= SYNC_IDLE;
        else     q_reg <= din;
      end
    end else begin : g_next
      always_ff @(posedge clk or posedge rst) begin
        if (rst) q_reg <= SYNC_IDLE;
        else     q_reg <= g_stage[gi-1].q_reg;
      end
    end
  end

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: IDLE/RUN/STOPPING FSM, 1-based pixel/line counters and delayed syncs.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int SYNC_DLY = 1,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  bus
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] x_reg, x_next;
  logic [CNT_W-1:0] y_reg, y_next;
  logic [CNT_W-1:0] x_adv, y_adv;
  logic             line_end, frame_end;
  logic             running, frame_start;
  logic [2:0]       sync_raw, sync_out;

  assign line_end  = (x_reg == H_LAST);
  assign frame_end = line_end && (y_reg == V_LAST);
  assign x_adv     = line_end ? 11'd1 : x_reg + 11'd1;
  assign y_adv     = !line_end ? y_reg : ((y_reg == V_LAST) ? 11'd1 : y_reg + 11'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
    end
  end

  // Dropping en only arms the stop; the frame always runs to (H_TOTAL, V_TOTAL).
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    case (state_reg)
      IDLE: begin
        if (bus.en) begin
          state_next = RUN;
          x_next     = 11'd1;
          y_next     = 11'd1;
        end
      end
      RUN: begin
        x_next = x_adv;
        y_next = y_adv;
        if (!bus.en) state_next = STOPPING;
      end
      STOPPING: begin
        if (bus.en) begin
          state_next = RUN;
          x_next     = x_adv;
          y_next     = y_adv;
        end else if (frame_end) begin
          state_next = IDLE;
          x_next     = '0;
          y_next     = '0;
        end else begin
          x_next = x_adv;
          y_next = y_adv;
        end
      end
      default: begin
        state_next = IDLE;
        x_next     = '0;
        y_next     = '0;
      end
    endcase
  end

  assign running     = (state_reg != IDLE);
  assign frame_start = (x_reg == 11'd1) && (y_reg == 11'd1);
  assign sync_raw    = running ? decode_sync(x_reg, y_reg) : SYNC_IDLE;

  vga_sync_dly #(.DEPTH(SYNC_DLY)) u_sync_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (sync_raw),
    .dout (sync_out)
  );

  assign bus.value_x     = x_reg;
  assign bus.value_y     = y_reg;
  assign bus.vga_hs      = sync_out[2];
  assign bus.vga_vs      = sync_out[1];
  assign bus.vga_de      = sync_out[0];
  assign bus.frame_start = frame_start;
  assign bus.running     = running;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              frame_cnt_reg <= '0;
    else if (frame_start) frame_cnt_reg <= frame_cnt_reg + 16'd1;
  end

  assign bus.frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line timing, short-line (H_TOTAL=10) instance
// for frame length, stop/restart and mid-frame reset behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();

  vga_timing_gen #(.SYNC_DLY(1), .H_TOTAL(800), .V_TOTAL(525)) u_a (
    .clk (clk),
    .rst (rst_a),
    .bus (if_a)
  );

  vga_timing_gen #(.SYNC_DLY(2), .H_TOTAL(10), .V_TOTAL(525)) u_b (
    .clk (clk),
    .rst (rst_b),
    .bus (if_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int de_cnt, hs_cnt, vs_cnt, fs_cnt, run_cnt, first_de_x, period;
    logic found;

    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.en = 1'b0;
    if_b.en = 1'b0;
    repeat (3) tick();

    chk("rst_x", if_a.value_x, 0);
    chk("rst_y", if_a.value_y, 0);
    chk("rst_hs", if_a.vga_hs, 1);
    chk("rst_vs", if_a.vga_vs, 1);
    chk("rst_de", if_a.vga_de, 0);
    chk("rst_fs", if_a.frame_start, 0);
    chk("rst_running", if_a.running, 0);

    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();
    chk("idle_x", if_a.value_x, 0);
    chk("idle_running", if_a.running, 0);

    // Start: first clock after IDLE->RUN is (1,1) with frame_start
    if_a.en = 1'b1;
    tick();
    chk("start_x", if_a.value_x, 1);
    chk("start_y", if_a.value_y, 1);
    chk("start_fs", if_a.frame_start, 1);
    chk("start_running", if_a.running, 1);
    chk("start_hs_idle", if_a.vga_hs, 1);

    // One line plus a few clocks of the next; sample i shows value_x = i+1 in line 1
    de_cnt = 0;
    hs_cnt = 0;
    first_de_x = 0;
    for (int i = 0; i < 804; i++) begin
      if (i > 0) tick();
      if (if_a.vga_de) begin
        de_cnt++;
        if (first_de_x == 0) first_de_x = int'(if_a.value_x);
      end
      if (i >= 100 && !if_a.vga_hs) hs_cnt++;
      if (i == 706) chk("hs_high_at_707", if_a.vga_hs, 1);
      if (i == 707) chk("hs_low_at_708", if_a.vga_hs, 0);
      if (i == 800) begin
        chk("wrap_x", if_a.value_x, 1);
        chk("wrap_y", if_a.value_y, 2);
        chk("wrap_fs", if_a.frame_start, 0);
      end
    end
    chk("line_de_cnt", de_cnt, 640);
    chk("line_de_first_x", first_de_x, 52);
    chk("line_hs_cnt", hs_cnt, 96);
    chk("line_hs_end", if_a.vga_hs, 1);
    chk("line_end_x", if_a.value_x, 4);

    // Asynchronous abort between clock edges
    @(posedge clk);
    #3;
    rst_a = 1'b1;
    #1;
    chk("abort_a_x", if_a.value_x, 0);
    chk("abort_a_y", if_a.value_y, 0);
    chk("abort_a_running", if_a.running, 0);
    chk("abort_a_hs", if_a.vga_hs, 1);
    chk("abort_a_de", if_a.vga_de, 0);
    tick();
    rst_a = 1'b0;
    tick();
    chk("reabort_a_x", if_a.value_x, 1);
    chk("reabort_a_y", if_a.value_y, 1);
    chk("reabort_a_fs", if_a.frame_start, 1);
    rst_a = 1'b1;

    // Short-line instance: frame = 10 x 525 = 5250 clocks, vs low for 2 lines = 20 clocks
    if_b.en = 1'b1;
    tick();
    chk("b_start_fs", if_b.frame_start, 1);
    period = 0;
    vs_cnt = 0;
    de_cnt = 0;
    for (int i = 1; i <= 6000 && period == 0; i++) begin
      tick();
      if (!if_b.vga_vs) vs_cnt++;
      if (if_b.vga_de) de_cnt++;
      if (if_b.frame_start) period = i;
    end
    chk("b_frame_period", period, 5250);
    chk("b_vs_low_cnt", vs_cnt, 20);
    chk("b_de_cnt", de_cnt, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("b_frame_cnt_1", if_b.frame_cnt, 1);
`endif

    // Drop en at line 100: frame completes, then idle with no further frames
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      if (if_b.value_y == 11'd100) found = 1'b1;
    end
    chk("b_wait_y100", found, 1);
    if_b.en = 1'b0;
    found = 1'b0;
    fs_cnt = 0;
    for (int i = 0; i < 6000 && !found; i++) begin
      tick();
      if (if_b.frame_start) fs_cnt++;
      if (if_b.value_x == 11'd10 && if_b.value_y == 11'd525) found = 1'b1;
    end
    chk("b_stop_reach_end", found, 1);
    chk("b_stop_fs_cnt", fs_cnt, 0);
    chk("b_stop_running_at_end", if_b.running, 1);
    tick();
    chk("b_stop_x", if_b.value_x, 0);
    chk("b_stop_y", if_b.value_y, 0);
    chk("b_stop_running", if_b.running, 0);
    chk("b_stop_fs", if_b.frame_start, 0);
    repeat (2) tick();
    chk("b_idle_hs", if_b.vga_hs, 1);
    chk("b_idle_vs", if_b.vga_vs, 1);
    chk("b_idle_de", if_b.vga_de, 0);
    fs_cnt = 0;
    run_cnt = 0;
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (if_b.frame_start) fs_cnt++;
      if (if_b.running) run_cnt++;
    end
    chk("b_idle_fs_cnt", fs_cnt, 0);
    chk("b_idle_run_cnt", run_cnt, 0);

    // Restart, drop en, re-raise before frame end: next frame follows with no gap
    if_b.en = 1'b1;
    tick();
    chk("b_restart_fs", if_b.frame_start, 1);
    chk("b_restart_x", if_b.value_x, 1);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      if (if_b.value_y == 11'd100) found = 1'b1;
    end
    chk("b_wait_y100_2", found, 1);
    if_b.en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      tick();
      if (if_b.value_y == 11'd300) found = 1'b1;
    end
    chk("b_wait_y300", found, 1);
    chk("b_stopping_running", if_b.running, 1);
    if_b.en = 1'b1;
    found = 1'b0;
    fs_cnt = 0;
    for (int i = 0; i < 6000 && !found; i++) begin
      tick();
      if (if_b.frame_start) fs_cnt++;
      if (if_b.value_x == 11'd10 && if_b.value_y == 11'd525) found = 1'b1;
    end
    chk("b_rerun_reach_end", found, 1);
    chk("b_rerun_fs_cnt", fs_cnt, 0);
    tick();
    chk("b_nogap_x", if_b.value_x, 1);
    chk("b_nogap_y", if_b.value_y, 1);
    chk("b_nogap_fs", if_b.frame_start, 1);
    chk("b_nogap_running", if_b.running, 1);

    // Mid-frame asynchronous reset at line 200
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      tick();
      if (if_b.value_y == 11'd200) found = 1'b1;
    end
    chk("b_wait_y200", found, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("b_frame_cnt_4", if_b.frame_cnt, 4);
`endif
    #2;
    rst_b = 1'b1;
    #1;
    chk("abort_b_x", if_b.value_x, 0);
    chk("abort_b_y", if_b.value_y, 0);
    chk("abort_b_hs", if_b.vga_hs, 1);
    chk("abort_b_vs", if_b.vga_vs, 1);
    chk("abort_b_de", if_b.vga_de, 0);
    chk("abort_b_fs", if_b.frame_start, 0);
    chk("abort_b_running", if_b.running, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("abort_b_frame_cnt", if_b.frame_cnt, 0);
`endif
    tick();
    rst_b = 1'b0;
    tick();
    chk("reabort_b_x", if_b.value_x, 1);
    chk("reabort_b_y", if_b.value_y, 1);
    chk("reabort_b_fs", if_b.frame_start, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
